// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bus of the ALU execution unit.
//   Request : in_valid, in_ready, in_op[3:0], in_a, in_b
//   Response: out_valid, out_ready, out_result, out_zero, out_illegal
// master = requester/consumer side, slave = the execution unit.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: executes one ALU control code per request and returns a
// registered result with zero/illegal flags on a second handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_exec_unit_if.slave (request + response handshakes)
//   busy       : FSM is not IDLE
// Optional macro ALU_EXEC_MUL_EN builds an iterative shift-add multiplier
// (code 1000, XLEN iterations). Without it, 1000 is an illegal code.
module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter int MUL_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus,
  output logic            busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Counter must be able to reach XLEN-1.
  if ((2 ** MUL_CNT_W) <= XLEN) begin : g_cnt_chk
    $error("alu_exec_unit: MUL_CNT_W too small for XLEN");
  end

  logic [1:0]      state;
  logic [XLEN-1:0] res_q;
  logic            zero_q;
  logic            ill_q;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  // Single-cycle datapath; illegal codes leave alu_res at 0.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.in_op)
      OP_AND:  alu_res = bus.in_a & bus.in_b;
      OP_OR:   alu_res = bus.in_a | bus.in_b;
      OP_ADD:  alu_res = bus.in_a + bus.in_b;
      OP_SUB:  alu_res = bus.in_a - bus.in_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      OP_NOR:  alu_res = ~(bus.in_a | bus.in_b);
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic [XLEN-1:0]      acc, mcand, mplier, acc_nxt;
  logic [MUL_CNT_W-1:0] cnt;
  logic                 mul_start, mul_last;

  assign mul_start = (state == S_IDLE) && bus.in_valid && (bus.in_op == OP_MUL);
  assign mul_last  = (cnt == MUL_CNT_W'(XLEN-1));
  assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;

  // Shift-add: only the low XLEN bits are kept, which matches both the
  // signed and unsigned low product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (mul_start) begin
      acc    <= '0;
      mcand  <= bus.in_a;
      mplier <= bus.in_b;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      res_q  <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
`ifdef ALU_EXEC_MUL_EN
            if (bus.in_op == OP_MUL) begin
              state <= S_MUL;
            end else
`endif
            begin
              state  <= S_RESP;
              res_q  <= alu_res;
              zero_q <= (alu_res == '0);
              ill_q  <= alu_ill;
            end
          end
        end
`ifdef ALU_EXEC_MUL_EN
        S_MUL: begin
          if (mul_last) begin
            state  <= S_RESP;
            res_q  <= acc_nxt;
            zero_q <= (acc_nxt == '0);
            ill_q  <= 1'b0;
          end
        end
`endif
        S_RESP: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register.
  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_RESP);
  assign busy            = (state != S_IDLE);
  assign bus.out_result  = res_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_illegal = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            z;
    logic            il;
    int              lat;
    int              acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic ov_prev = 1'b0;
  exp_t sb[$];

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN), .MUL_CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency on out_valid rise, fields on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_result", 64'(bus.out_result), 64'(e.res));
        chk("out_zero", 64'(bus.out_zero), 64'(e.z));
        chk("out_illegal", 64'(bus.out_illegal), 64'(e.il));
      end
      ov_prev <= bus.out_valid;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] r, input logic z, input logic il, input int lat);
    exp_t e;
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    e.res = r; e.z = z; e.il = il; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = '1;
    bus.in_b = '1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && bus.in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op = 4'b0000;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    #12;
    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_out_result", 64'(bus.out_result), 0);
    chk("rst_flags", 64'({bus.out_zero, bus.out_illegal}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with in_ready returning the cycle after the handshake
    issue(4'b0010, 5, 7, 12, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("add_in_ready_back", 64'(bus.in_ready), 1);
    chk("add_out_valid_fell", 64'(bus.out_valid), 0);
    @(posedge clk); #1;

    // Back-to-back single-cycle ops
    issue(4'b0110, 0, 1, 32'hFFFF_FFFF, 0, 0, 1);
    issue(4'b0110, 3, 3, 0, 1, 0, 1);
    issue(4'b0010, 32'hFFFF_FFFF, 1, 0, 1, 0, 1);
    issue(4'b0111, 32'hFFFF_FFFF, 1, 1, 0, 0, 1);
    issue(4'b0111, 1, 32'hFFFF_FFFF, 0, 1, 0, 1);
    issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 1);
    issue(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0, 0, 1);
    issue(4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 0, 0, 1);
    wait_idle();

`ifdef ALU_EXEC_MUL_EN
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000, 0, 1, 0, 33);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("mul_busy", 64'(busy), 1);
    end
    @(posedge clk); #1;
    wait_idle();
    issue(4'b1000, 123, 456, 56088, 0, 0, 33);
    wait_idle();
`else
    issue(4'b1000, 123, 456, 0, 1, 1, 1);
    wait_idle();
`endif

    // Illegal code stalled in RESP; request pulses must be ignored
    bus.out_ready = 1'b0;
    issue(4'b0101, 9, 9, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(bus.out_valid), 1);
      chk("stall_result", 64'(bus.out_result), 0);
      chk("stall_illegal", 64'(bus.out_illegal), 1);
      chk("stall_in_ready", 64'(bus.in_ready), 0);
      bus.in_valid = i[0];
      bus.in_op = 4'b0010;
      bus.in_a = 40;
      bus.in_b = 2;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();

    // Asynchronous reset mid-operation
    bus.out_ready = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    issue(4'b1000, 3, 5, 15, 0, 0, 33);
    repeat (9) @(posedge clk);
    #1;
`else
    issue(4'b0010, 1, 2, 3, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
`endif
    chk("pre_rst_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", 64'(bus.out_valid), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_out_result", 64'(bus.out_result), 0);
    chk("arst_in_ready", 64'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'b0010, 1, 1, 2, 0, 0, 1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side responder for the 4-bit ALU control code produced by the ALU control decoder.
- Accepts one operation (code plus two XLEN operands) per valid/ready handshake and returns a registered result with zero and illegal flags on a second handshake.
- Adds an iterative multi-cycle multiply path. This is the first block on the path from single-cycle toward multi-cycle execution.

Parameters:
- XLEN, 32, operand and result width in bits (≥ 8).
- MUL_CNT_W, 6, multiply iteration counter width; must satisfy 2^MUL_CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_op  input  4  ALU control code
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  XLEN  result
- out_zero  output  1  out_result == 0
- out_illegal  output  1  in_op was unsupported
- busy  output  1  state != IDLE

Behaviour:
- Opcode map:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed; result 1 or 0)
  - 1100 NOR
  - 1000 MUL (low XLEN bits of the unsigned product, which are identical to the low bits of the signed product)
  - any other code is illegal.
- Arithmetic: ADD and SUB wrap modulo 2^XLEN; no carry or overflow outputs.
- FSM states: IDLE, MUL, RESP. Reset state is IDLE.
- Reset values: out_valid 0, out_result 0, out_zero 0, out_illegal 0, busy 0, in_ready 1 (in_ready is decoded from IDLE).
- in_ready = 1 only in IDLE. No request is accepted while in MUL or RESP.
- Accept occurs when in_valid && in_ready. Operands and op are captured at accept; later changes on the in_* ports are ignored.
- Single-cycle ops and illegal codes: IDLE→RESP. out_valid rises on the first clock edge after accept (latency 1).
- Illegal code: out_result = 0, out_zero = 1, out_illegal = 1.
- MUL, IDLE→MUL: product accumulator cleared, counter = 0.
  - Each cycle: if multiplier bit0 is set, add the shifted multiplicand to the accumulator; then shift multiplicand left and multiplier right; counter increments.
  - After XLEN iterations → RESP. out_valid rises XLEN+1 edges after accept.
- RESP:
  - out_valid = 1; out_result, out_zero and out_illegal are held stable until out_ready.
  - out_valid && out_ready → IDLE at that edge; out_valid falls the same edge.
  - Next accept is possible on the following cycle, so the peak rate is one op per 2 cycles.
- out_zero and out_illegal are registered together with out_result; they are never combinational from the inputs.
- out_ready asserted while not in RESP: ignored.
- Asynchronous reset in any state (including mid-MUL or mid-RESP): the in-flight op is discarded, all outputs take their reset values immediately, and the FSM is in IDLE after release.

Optional Feature:
- Macro ALU_EXEC_MUL_EN.
- Defined: MUL state, counter and accumulator are built; 1000 is executed as described above.
- Undefined: no MUL datapath is built; 1000 is treated as illegal (result 0, out_zero 1, out_illegal 1, latency 1); the FSM has IDLE and RESP only.

Test Plan:
- ADD a=5, b=7, out_ready held 1 → out_valid one edge after accept, out_result=12, out_zero=0, out_illegal=0; in_ready back to 1 the following cycle.
- SUB a=0, b=1 → out_result=0xFFFFFFFF. Then SUB a=3, b=3 → out_result=0, out_zero=1.
- SLT a=0xFFFFFFFF, b=1 → 1. SLT a=1, b=0xFFFFFFFF → 0. AND/OR/NOR with 0xF0F0F0F0 / 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0 / 0x000F000F.
- MUL with macro on:
  - a=0x00010000, b=0x00010000 → out_valid 33 edges after accept, out_result=0, out_zero=1, busy high throughout.
  - a=123, b=456 → 56088.
  - With macro off, in_op=1000 → out_illegal=1 after 1 edge.
- Illegal code 0101 with out_ready low for 5 cycles → out_valid, out_result=0 and out_illegal=1 all stable; in_ready=0; in_valid pulses are ignored until the handshake completes.
- rst_n asserted at MUL iteration 10 → out_valid, busy and out_result go to 0 immediately, in_ready=1. After release, a fresh ADD 1+1 returns 2 with latency 1.
